// File: rtl/debug_pkg.sv
// Shared constants and state encoding for the debug execution controller.
// Command bytes, the FSM state set and the default report frame length.
package debug_pkg;

  localparam logic [7:0] CMD_RUN    = 8'h63;
  localparam logic [7:0] CMD_STEP   = 8'h73;
  localparam logic [7:0] CMD_REPORT = 8'h72;

  localparam int PC_W_DEF    = 32;
  localparam int CNT_W_DEF   = 32;
  localparam int BYTE_W_DEF  = 8;
  localparam int FRAME_BYTES = (PC_W_DEF + CNT_W_DEF) / BYTE_W_DEF;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_STEP    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_SEND    = 3'd4
  } state_e;

  function automatic int frame_bytes(input int pc_w, input int cnt_w, input int byte_w);
    return (pc_w + cnt_w) / byte_w;
  endfunction

endpackage

// File: rtl/debug_exec_ctrl_if.sv
// Command and transmit byte channels between the debug host side and the controller.
// master = host/UART side, slave = execution controller.
interface debug_exec_ctrl_if #(
  parameter int BYTE_W = 8
);

  logic              cmd_valid;
  logic [BYTE_W-1:0] cmd_data;
  logic              cmd_ready;
  logic              tx_valid;
  logic [BYTE_W-1:0] tx_data;
  logic              tx_ready;

  modport master (
    output cmd_valid,
    output cmd_data,
    input  cmd_ready,
    input  tx_valid,
    input  tx_data,
    output tx_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_data,
    output cmd_ready,
    output tx_valid,
    output tx_data,
    input  tx_ready
  );

endinterface

// File: rtl/debug_frame_tx.sv
// Report frame serializer: loads {count, pc} on a pulse, then emits it LSB byte first
// over a valid/ready channel and pulses o_done when the last byte is taken.
module debug_frame_tx #(
  parameter int BYTE_W      = 8,
  parameter int FRAME_BYTES = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          i_load,
  input  logic [FRAME_BYTES*BYTE_W-1:0] i_frame,
  output logic                          o_tx_valid,
  output logic [BYTE_W-1:0]             o_tx_data,
  input  logic                          i_tx_ready,
  output logic                          o_done
);

  localparam int FRAME_W = FRAME_BYTES * BYTE_W;
  localparam int IDX_W   = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;

  logic [FRAME_W-1:0] r_frame;
  logic               r_valid;
  logic [IDX_W-1:0]   r_idx;
  logic               w_fire;
  logic               w_last;

  assign w_fire = r_valid && i_tx_ready;
  assign w_last = (r_idx == IDX_W'(FRAME_BYTES - 1));

  // Shift register keeps the current byte in the low lane so tx_data is a plain slice
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_frame <= '0;
      r_valid <= 1'b0;
      r_idx   <= '0;
    end else if (i_load) begin
      r_frame <= i_frame;
      r_valid <= 1'b1;
      r_idx   <= '0;
    end else if (w_fire) begin
      r_frame <= {{BYTE_W{1'b0}}, r_frame[FRAME_W-1:BYTE_W]};
      if (w_last) begin
        r_valid <= 1'b0;
        r_idx   <= '0;
      end else begin
        r_idx <= r_idx + IDX_W'(1);
      end
    end
  end

  assign o_tx_valid = r_valid;
  assign o_tx_data  = r_frame[BYTE_W-1:0];
  assign o_done     = w_fire && w_last;

endmodule

// File: rtl/debug_exec_ctrl.sv
// Debug-unit execution controller: drives the pipeline clock enable (db_ena) for
// run/step commands, detects program end and reports PC and executed-cycle count.
module debug_exec_ctrl
  import debug_pkg::*;
#(
  parameter int PC_W   = 32,
  parameter int CNT_W  = 32,
  parameter int BYTE_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  debug_exec_ctrl_if.slave  bus,
  input  logic [PC_W-1:0]   pc_in,
  input  logic              halt_in,
  output logic              db_ena,
  output logic              halted,
  output logic              busy
);

  localparam int NBYTES = frame_bytes(PC_W, CNT_W, BYTE_W);

  if ((PC_W % BYTE_W) != 0 || (CNT_W % BYTE_W) != 0) begin : g_bad_width
    $error("debug_exec_ctrl: PC_W and CNT_W must be multiples of BYTE_W");
  end

  state_e            r_state;
  state_e            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_halted;
  logic              w_cmd_fire;
  logic              w_exec;
  logic              w_load;
  logic              w_done;

  assign w_cmd_fire    = bus.cmd_valid && bus.cmd_ready;
  assign w_exec        = (r_state == ST_RUN) || (r_state == ST_STEP);
  assign w_load        = (r_state == ST_CAPTURE);
  assign bus.cmd_ready = (r_state == ST_IDLE);
  assign db_ena        = w_exec;
  assign busy          = (r_state != ST_IDLE);
  assign halted        = r_halted;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_cmd_fire) begin
          if (bus.cmd_data == BYTE_W'(CMD_RUN))
            w_state_nxt = ST_RUN;
          else if (bus.cmd_data == BYTE_W'(CMD_STEP))
            w_state_nxt = ST_STEP;
          else if (bus.cmd_data == BYTE_W'(CMD_REPORT))
            w_state_nxt = ST_CAPTURE;
        end
      end
      ST_RUN:     if (halt_in) w_state_nxt = ST_CAPTURE;
      ST_STEP:    w_state_nxt = ST_CAPTURE;
      ST_CAPTURE: w_state_nxt = ST_SEND;
      ST_SEND:    if (w_done) w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // Every enabled pipeline cycle is counted, including the one that raises halt
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_halted <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_exec) begin
        r_cnt <= r_cnt + CNT_W'(1);
        if (halt_in) r_halted <= 1'b1;
      end
    end
  end

  // CAPTURE sits one cycle after the last enabled edge, so pc_in is already updated
  debug_frame_tx #(
    .BYTE_W      (BYTE_W),
    .FRAME_BYTES (NBYTES)
  ) u_frame_tx (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_load),
    .i_frame    ({r_cnt, pc_in}),
    .o_tx_valid (bus.tx_valid),
    .o_tx_data  (bus.tx_data),
    .i_tx_ready (bus.tx_ready),
    .o_done     (w_done)
  );

endmodule

// File: tb/tb_debug_exec_ctrl.sv
// Directed bench for debug_exec_ctrl: step, run-to-halt, report, tx stall,
// unknown command and asynchronous reset in mid-run and mid-send.
module tb_debug_exec_ctrl;
  import debug_pkg::*;

  logic        clk;
  logic        reset;
  logic [31:0] pc_in;
  logic        halt_in;
  logic        db_ena;
  logic        halted;
  logic        busy;

  int n_asserts = 0;
  int n_fail    = 0;
  int ena_total = 0;
  logic [7:0] rx[$];

  debug_exec_ctrl_if #(.BYTE_W(8)) u_if ();

  debug_exec_ctrl #(
    .PC_W   (32),
    .CNT_W  (32),
    .BYTE_W (8)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (u_if.slave),
    .pc_in   (pc_in),
    .halt_in (halt_in),
    .db_ena  (db_ena),
    .halted  (halted),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (db_ena) ena_total++;
    if (u_if.tx_valid && u_if.tx_ready) rx.push_back(u_if.tx_data);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] frame_at(input int base);
    logic [63:0] v = '0;
    for (int i = 0; i < 8; i++)
      if (base + i < rx.size()) v[8*i +: 8] = rx[base + i];
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [7:0] b);
    u_if.cmd_valid = 1'b1;
    u_if.cmd_data  = b;
    tick();
    u_if.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n   = 0;
    int bad = 0;
    @(negedge clk);
    while (busy && n < budget) begin
      if (u_if.cmd_ready) bad++;
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 64'(n < budget), 64'd1);
    chk("cmd_ready_while_busy", 64'(bad), 64'd0);
    tick();
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    int r0;
    reset          = 1'b1;
    pc_in          = 32'h0;
    halt_in        = 1'b0;
    u_if.cmd_valid = 1'b0;
    u_if.cmd_data  = 8'h00;
    u_if.tx_ready  = 1'b1;
    tick();
    tick();
    chk("rst_db_ena", 64'(db_ena), 64'd0);
    chk("rst_tx_valid", 64'(u_if.tx_valid), 64'd0);
    chk("rst_tx_data", 64'(u_if.tx_data), 64'd0);
    chk("rst_halted", 64'(halted), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    reset = 1'b0;
    tick();
    chk("idle_cmd_ready", 64'(u_if.cmd_ready), 64'd1);

    // single step; PC changes only after the step edge
    e0 = ena_total; r0 = rx.size();
    send_cmd(CMD_STEP);
    chk("step_ena_lat", 64'(db_ena), 64'd1);
    chk("step_cmd_ready", 64'(u_if.cmd_ready), 64'd0);
    tick();
    pc_in = 32'h0000_0004;
    chk("cap_db_ena", 64'(db_ena), 64'd0);
    chk("cap_tx_valid", 64'(u_if.tx_valid), 64'd0);
    tick();
    chk("send_tx_valid_lat", 64'(u_if.tx_valid), 64'd1);
    chk("send_byte0", 64'(u_if.tx_data), 64'h04);
    wait_idle(100);
    chk("step_ena_cycles", 64'(ena_total - e0), 64'd1);
    chk("step_nbytes", 64'(rx.size() - r0), 64'd8);
    chk("step_frame", frame_at(r0), 64'h00000001_00000004);
    chk("step_busy_end", 64'(busy), 64'd0);
    chk("step_tx_valid_end", 64'(u_if.tx_valid), 64'd0);
    chk("step_halted", 64'(halted), 64'd0);

    // run until halt after 10 enabled cycles
    pulse_reset();
    pc_in = 32'h0;
    e0 = ena_total; r0 = rx.size();
    send_cmd(CMD_RUN);
    repeat (9) tick();
    halt_in = 1'b1;
    pc_in   = 32'h0000_002C;
    tick();
    chk("run_halt_db_ena", 64'(db_ena), 64'd0);
    chk("run_halted", 64'(halted), 64'd1);
    halt_in = 1'b0;
    wait_idle(100);
    chk("run_ena_cycles", 64'(ena_total - e0), 64'd10);
    chk("run_frame", frame_at(r0), 64'h0000000A_0000002C);

    // report only
    e0 = ena_total; r0 = rx.size();
    send_cmd(CMD_REPORT);
    chk("rep_db_ena", 64'(db_ena), 64'd0);
    wait_idle(100);
    chk("rep_ena_cycles", 64'(ena_total - e0), 64'd0);
    chk("rep_frame", frame_at(r0), 64'h0000000A_0000002C);
    chk("rep_halted_sticky", 64'(halted), 64'd1);

    // tx stall on byte 2
    pc_in = 32'h1122_3344;
    r0 = rx.size();
    send_cmd(CMD_REPORT);
    tick();
    chk("stall_b0", 64'(u_if.tx_data), 64'h44);
    tick();
    chk("stall_b1", 64'(u_if.tx_data), 64'h33);
    tick();
    u_if.tx_ready = 1'b0;
    chk("stall_b2", 64'(u_if.tx_data), 64'h22);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_valid", 64'(u_if.tx_valid), 64'd1);
      chk("stall_data", 64'(u_if.tx_data), 64'h22);
    end
    u_if.tx_ready = 1'b1;
    tick();
    chk("stall_b3", 64'(u_if.tx_data), 64'h11);
    wait_idle(100);
    chk("stall_nbytes", 64'(rx.size() - r0), 64'd8);
    chk("stall_frame", frame_at(r0), 64'h0000000A_11223344);

    // unknown byte then step back to back
    pc_in = 32'h0000_0030;
    e0 = ena_total; r0 = rx.size();
    send_cmd(8'h41);
    chk("junk_db_ena", 64'(db_ena), 64'd0);
    chk("junk_busy", 64'(busy), 64'd0);
    chk("junk_cmd_ready", 64'(u_if.cmd_ready), 64'd1);
    send_cmd(CMD_STEP);
    chk("b2b_step_ena", 64'(db_ena), 64'd1);
    wait_idle(100);
    chk("b2b_ena_cycles", 64'(ena_total - e0), 64'd1);
    chk("b2b_frame", frame_at(r0), 64'h0000000B_00000030);
    chk("b2b_halted", 64'(halted), 64'd1);

    // reset in the middle of RUN
    send_cmd(CMD_RUN);
    repeat (3) tick();
    chk("mid_run_db_ena", 64'(db_ena), 64'd1);
    reset = 1'b1;
    #1;
    chk("rst_run_db_ena", 64'(db_ena), 64'd0);
    chk("rst_run_halted", 64'(halted), 64'd0);
    chk("rst_run_busy", 64'(busy), 64'd0);
    tick();
    reset = 1'b0;
    r0 = rx.size();
    send_cmd(CMD_REPORT);
    wait_idle(100);
    chk("rst_run_frame", frame_at(r0), 64'h00000000_00000030);

    // reset in the middle of SEND
    pc_in = 32'h0000_0055;
    send_cmd(CMD_REPORT);
    tick();
    tick();
    chk("mid_send_valid", 64'(u_if.tx_valid), 64'd1);
    reset = 1'b1;
    #1;
    chk("rst_send_valid", 64'(u_if.tx_valid), 64'd0);
    chk("rst_send_data", 64'(u_if.tx_data), 64'd0);
    chk("rst_send_busy", 64'(busy), 64'd0);
    tick();
    reset = 1'b0;
    tick();
    chk("rst_send_no_resume", 64'(u_if.tx_valid), 64'd0);
    r0 = rx.size();
    send_cmd(CMD_REPORT);
    wait_idle(100);
    chk("rst_send_nbytes", 64'(rx.size() - r0), 64'd8);
    chk("rst_send_frame", frame_at(r0), 64'h00000000_00000055);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/debug_exec_ctrl.md
Name: debug_exec_ctrl

Overview:
- Debug-unit execution controller driving the PC clock-enable (db_ena) of the pipeline, i.e. the controlling end of the db_ena / PC_end interface.
- Accepts single-byte commands over a valid/ready channel, runs the pipeline continuously or one cycle at a time, and detects program end.
- Returns the current PC and the executed-cycle count as a byte stream over a valid/ready transmit channel toward the UART TX.

Parameters:
- PC_W, 32, width of the PC value reported.
- CNT_W, 32, width of the executed-cycle counter.
- BYTE_W, 8, width of command and transmit bytes.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- cmd_valid  in  1  command byte available.
- cmd_data  in  BYTE_W  command byte.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- pc_in  in  PC_W  current PC from the pipeline.
- halt_in  in  1  program-end flag from the pipeline (PC_end path).
- db_ena  out  1  pipeline/PC clock enable.
- tx_valid  out  1  transmit byte valid.
- tx_data  out  BYTE_W  transmit byte.
- tx_ready  in  1  transmit sink ready.
- halted  out  1  sticky flag, program end reached.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: state=IDLE, db_ena=0, tx_valid=0, tx_data=0, halted=0, cycle counter=0, byte index=0.
- Reset is asynchronous. Asserting it mid-run or mid-send aborts immediately. The partial frame is dropped with no resume.
- Command codes: 0x63 'c' = RUN, 0x73 's' = STEP, 0x72 'r' = REPORT. Any other byte is consumed with no effect.
- FSM states: IDLE, RUN, STEP, CAPTURE, SEND.
- db_ena is decoded combinationally from state: high in RUN and STEP, low otherwise.
- IDLE:
  - cmd_ready=1.
  - On handshake: 'c' -> RUN, 's' -> STEP, 'r' -> CAPTURE, other -> IDLE.
- RUN:
  - Every cycle, cycle counter +1, wrapping modulo 2^CNT_W.
  - If halt_in=1 at a rising edge: -> CAPTURE and set halted=1. The db_ena of that cycle still counts.
  - If halt_in is already high on entry, exactly one db_ena cycle occurs, then CAPTURE.
- STEP:
  - Exactly one cycle with db_ena=1; counter +1; then -> CAPTURE.
  - If halt_in=1 in that cycle, halted is set.
- CAPTURE:
  - db_ena=0 for one cycle.
  - Latch pc_in and the cycle counter into an 8-byte frame register. The PC sampled is the value after the step/run edge.
  - Then -> SEND.
- SEND:
  - Frame order: PC bytes little-endian (byte0 = PC[7:0]) followed by the counter bytes little-endian. Total PC_W/8 + CNT_W/8 bytes (8 at defaults).
  - tx_valid=1 and tx_data holds the current byte.
  - tx_data stays stable while tx_valid && !tx_ready.
  - On each tx_valid && tx_ready, byte index +1.
  - After the last byte is accepted: tx_valid=0 in the next cycle, index=0, -> IDLE.
  - tx_ready held low means SEND waits indefinitely.
- Commands are never buffered: cmd_ready=0 in every state except IDLE.
- halted is cleared only by reset. Further 'c'/'s' commands are still honoured; the pipeline itself blocks further PC advance.
- Latencies:
  - Command accept to first db_ena: 1 cycle.
  - STEP accept to first tx_valid: 3 cycles.
- PC_W and CNT_W must be multiples of BYTE_W. This is elaborate-time checked.

Decomposition:
- Shared package debug_pkg holds:
  - Command code constants CMD_RUN=8'h63, CMD_STEP=8'h73, CMD_REPORT=8'h72.
  - The state enum.
  - FRAME_BYTES = (PC_W+CNT_W)/BYTE_W.
- One natural sub-module, debug_frame_tx:
  - Loads the frame register on a load pulse.
  - Serializes it byte by byte over the valid/ready channel.
  - Returns a done pulse to the FSM.

Test Plan:
- Reset then 's' with pc_in = 0x00000004 after the edge -> db_ena high for exactly 1 cycle. tx bytes 04 00 00 00 01 00 00 00, then busy=0.
- 'c' with halt_in raised after 10 db_ena cycles and pc_in=0x0000002C -> db_ena high for 10 cycles, halted=1. Frame 2C 00 00 00 0A 00 00 00.
- 'r' after the previous test -> no db_ena. Frame repeats the PC, count still 0x0A.
- tx_ready low for 5 cycles on byte 2 -> tx_valid stays 1 and tx_data constant. Byte 3 follows the first ready.
- Send 0x41 then 's' back-to-back -> 0x41 consumed, no db_ena. The step executes and cmd_ready=0 until the frame completes.
- Assert reset mid-RUN and mid-SEND -> db_ena, tx_valid and halted go to 0 immediately. The counter reads 0 on the next 'r'.
